y_pc_fetch: RTL and testbench
=============================

// Module: y_pc_fetch
// PURPOSE
//  Fetch-stage program counter: registers the next PC chosen from four sources (seq/branch/jump/jr)
//  and drives a valid/ready request to instruction memory. Sits directly upstream of the 4-to-1
//  next-PC mux output consumer path: mux selects the target, this block owns the PC register.
//  Halts on misaligned targets.
// PARAMETERS
//  WIDTH     32            address/PC width
//  RESET_PC  32'h0040_0000 PC loaded on reset (text segment base)
//  STEP      4             sequential increment in bytes
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      reset, synchronous, active-low
//  redirect_valid  in   1      apply sel/target this cycle
//  sel             in   2      00 seq(pc+STEP), 01 branch_tgt, 10 jump_tgt, 11 jr_tgt
//  branch_tgt      in   WIDTH  branch target
//  jump_tgt        in   WIDTH  jump target
//  jr_tgt          in   WIDTH  register-jump target
//  stall           in   1      hold PC, withdraw request
//  imem_req_valid  out  1      fetch request valid
//  imem_req_ready  in   1      instruction memory accepts request
//  imem_addr       out  WIDTH  fetch address (== pc)
//  pc              out  WIDTH  current PC
//  pc_plus4        out  WIDTH  pc + STEP (for link/branch adders)
//  misalign        out  1      sticky: misaligned target taken, block halted
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=BOOT, pc=RESET_PC, imem_req_valid=0, misalign=0. Overrides all.
//  - FSM: BOOT -> REQ unconditionally next cycle; REQ -> HALT on misaligned redirect; HALT -> only reset.
//  - Latency: first imem_req_valid=1 with imem_addr=RESET_PC on 2nd edge after rst_n rises.
//  - imem_req_valid = (state==REQ) & ~stall. Handshake = imem_req_valid & imem_req_ready.
//  - Priority at each edge in REQ: redirect_valid > handshake > hold.
//    * redirect_valid=1: pc <= mux(sel) regardless of stall/ready; a same-cycle handshake still counts
//      as fetching the old pc. sel=00 under redirect == pc+STEP.
//    * else handshake: pc <= pc+STEP.  * else: pc holds.
//  - Stability: while valid & ~ready, imem_addr holds unless redirect (redirect = cancel + re-request).
//  - Misaligned: selected target[1:0]!=0 -> pc <= target, misalign <= 1, state HALT, valid=0 forever.
//  - Wrap: pc+STEP modulo 2^WIDTH (32'hFFFF_FFFC -> 0), no flag.
//  - pc_plus4 combinational from pc; imem_addr wired to pc.
// CONFIGURATION
//  - Macro Y_PC_FETCH_COUNT_EN defined: adds output fetch_count [31:0], reset 0, +1 per handshake,
//    wraps at 2^32; held in HALT.
//  - Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Shared package y_cpu_pkg: SEL_SEQ/SEL_BR/SEL_J/SEL_JR 2-bit codes, FSM state enum
//    (ST_BOOT, ST_REQ, ST_HALT), DEFAULT_RESET_PC.
//  - Sub-module: next-target select via yMux4to1 #(.SIZE(WIDTH)); rest (FSM, PC reg, counter) local.
// TESTING
//  - Reset: rst_n=0 2 cycles, release -> cycle1 valid=0; cycle2 valid=1, addr=32'h0040_0000.
//  - Sequential: ready=1 for 3 cycles -> addrs 0x400000, 0x400004, 0x400008; ready=0 -> addr held.
//  - Stall: stall=1 at pc=0x400008 with ready=1 -> valid=0, pc holds 3 cycles; release -> 0x400008.
//  - Redirect: same cycle handshake at 0x40000C and redirect sel=01 branch_tgt=0x400100 ->
//    next addr 0x400100 (not 0x400010); sel=11 jr_tgt=0x400200 under stall -> pc=0x400200.
//  - Misalign: redirect sel=10 jump_tgt=0x400102 -> misalign=1, pc=0x400102, valid=0 until reset.
//  - Wrap + option: pc=0xFFFF_FFFC handshake -> pc=0; with Y_PC_FETCH_COUNT_EN, fetch_count==handshakes.

Source files
------------

// File: rtl/y_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y_cpu_pkg
//  Description : Shared CPU front-end definitions.
//                - 2-bit next-PC select codes (SEL_SEQ/SEL_BR/SEL_J/SEL_JR)
//                - Fetch FSM state enum (ST_BOOT, ST_REQ, ST_HALT)
//                - DEFAULT_RESET_PC, the text segment base
//  Revision    : 1.0  initial release
// ============================================================================
package y_cpu_pkg;

    localparam logic [1:0] SEL_SEQ = 2'b00;  // pc + STEP
    localparam logic [1:0] SEL_BR  = 2'b01;  // branch target
    localparam logic [1:0] SEL_J   = 2'b10;  // jump target
    localparam logic [1:0] SEL_JR  = 2'b11;  // register-jump target

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/yMux4to1.sv
`default_nettype none
// ============================================================================
//  Module      : yMux4to1
//  Description : SIZE-bit 4-to-1 multiplexer, select encoded with the
//                y_cpu_pkg SEL_* codes.
//  Ports       : sel [1:0]            select code
//                in0..in3 [SIZE-1:0]  data inputs (seq, branch, jump, jr)
//                out [SIZE-1:0]       selected data
//  Revision    : 1.0  initial release
// ============================================================================
module yMux4to1
    import y_cpu_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic [1:0]      sel,
    input  logic [SIZE-1:0] in0,
    input  logic [SIZE-1:0] in1,
    input  logic [SIZE-1:0] in2,
    input  logic [SIZE-1:0] in3,
    output logic [SIZE-1:0] out
);

    always_comb begin
        out = in0;
        case (sel)
            SEL_SEQ: out = in0;
            SEL_BR:  out = in1;
            SEL_J:   out = in2;
            SEL_JR:  out = in3;
            default: out = in0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/y_pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : y_pc_fetch
//  Description : Fetch-stage program counter. Owns the PC register, picks the
//                next PC from seq/branch/jump/jr sources and issues a
//                valid/ready request to instruction memory. A misaligned
//                redirect target is loaded, flagged sticky and halts fetch
//                until reset.
//  Option      : `define Y_PC_FETCH_COUNT_EN adds fetch_count[31:0], a
//                wrapping count of accepted fetch handshakes.
//  Ports       : clk, rst_n (sync, active-low)
//                redirect_valid, sel[1:0], branch_tgt, jump_tgt, jr_tgt
//                stall, imem_req_ready
//                imem_req_valid, imem_addr, pc, pc_plus4, misalign
//                fetch_count (option only)
//  Revision    : 1.0  initial release
// ============================================================================
module y_pc_fetch
    import y_cpu_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned      STEP     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_valid,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] branch_tgt,
    input  logic [WIDTH-1:0] jump_tgt,
    input  logic [WIDTH-1:0] jr_tgt,
    input  logic             stall,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
`ifdef Y_PC_FETCH_COUNT_EN
    output logic [31:0]      fetch_count,
`endif
    output logic             misalign
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic [WIDTH-1:0] target;
    logic             handshake;

    // Sequential increment wraps naturally modulo 2^WIDTH.
    assign pc_plus4       = pc_q + WIDTH'(STEP);
    assign pc             = pc_q;
    assign imem_addr      = pc_q;
    assign misalign       = misalign_q;
    assign imem_req_valid = (state_q == ST_REQ) && !stall;
    assign handshake      = imem_req_valid && imem_req_ready;

    yMux4to1 #(.SIZE(WIDTH)) u_next_mux (
        .sel (sel),
        .in0 (pc_plus4),
        .in1 (branch_tgt),
        .in2 (jump_tgt),
        .in3 (jr_tgt),
        .out (target)
    );

    // Redirect beats handshake; a same-cycle handshake still fetched the old
    // pc, so the redirect simply replaces the post-increment value.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = target;
                    if (target[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end
                end else if (handshake) begin
                    pc_d = pc_plus4;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef Y_PC_FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Handshakes only occur in ST_REQ, so the count freezes in ST_HALT.
    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, handshake};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_y_pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y_pc_fetch
//  Description : Self-checking bench for y_pc_fetch. A vector table drives
//                one cycle per entry and checks the pre-edge outputs; short
//                hand-written sequences cover reset recovery.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_y_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [1:0]  sel;
    logic [31:0] branch_tgt, jump_tgt, jr_tgt;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr, pc, pc_plus4;
    logic        misalign;
`ifdef Y_PC_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    y_pc_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .sel            (sel),
        .branch_tgt     (branch_tgt),
        .jump_tgt       (jump_tgt),
        .jr_tgt         (jr_tgt),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
`ifdef Y_PC_FETCH_COUNT_EN
        .fetch_count    (fetch_count),
`endif
        .misalign       (misalign)
    );

    typedef struct {
        logic        rdv;
        logic [1:0]  sel;
        logic [31:0] br;
        logic [31:0] j;
        logic [31:0] jr;
        logic        stall;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    // Places tgt on the field sel picks; the other target inputs get decoys
    // so a wrong mux leg shows up as a wrong PC.
    function automatic vec_t mk(input logic rdv, input logic [1:0] s,
                                input logic [31:0] tgt, input logic st,
                                input logic rdy, input logic ev,
                                input logic [31:0] ea, input logic em);
        vec_t v;
        v.rdv = rdv; v.sel = s;
        v.br  = (s == 2'b01) ? tgt : 32'h0000_1110;
        v.j   = (s == 2'b10) ? tgt : 32'h0000_2220;
        v.jr  = (s == 2'b11) ? tgt : 32'h0000_3330;
        v.stall = st; v.ready = rdy;
        v.exp_valid = ev; v.exp_addr = ea; v.exp_mis = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0; sel = 2'b00; stall = 1'b0; imem_req_ready = 1'b0;
        branch_tgt = 32'h0000_1110; jump_tgt = 32'h0000_2220; jr_tgt = 32'h0000_3330;
    endtask

    task automatic check_outputs(input string tag, input logic ev,
                                 input logic [31:0] ea, input logic em);
        chk({tag, ".valid"},    {31'd0, imem_req_valid}, {31'd0, ev});
        chk({tag, ".addr"},     imem_addr, ea);
        chk({tag, ".pc"},       pc, ea);
        chk({tag, ".pc_plus4"}, pc_plus4, ea + 32'd4);
        chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, em});
    endtask

    int exp_hs;

    initial begin
        // ----- vector table: inputs for one cycle, outputs seen before the edge
        vecs[0]  = mk(0, 2'b00, 32'h0,         0, 0, 0, 32'h0040_0000, 0); // BOOT
        vecs[1]  = mk(0, 2'b00, 32'h0,         0, 1, 1, 32'h0040_0000, 0);
        vecs[2]  = mk(0, 2'b00, 32'h0,         0, 1, 1, 32'h0040_0004, 0);
        vecs[3]  = mk(0, 2'b00, 32'h0,         0, 0, 1, 32'h0040_0008, 0);
        vecs[4]  = mk(0, 2'b00, 32'h0,         0, 0, 1, 32'h0040_0008, 0); // held, not ready
        vecs[5]  = mk(0, 2'b00, 32'h0,         1, 1, 0, 32'h0040_0008, 0); // stall
        vecs[6]  = mk(0, 2'b00, 32'h0,         1, 1, 0, 32'h0040_0008, 0);
        vecs[7]  = mk(0, 2'b00, 32'h0,         1, 1, 0, 32'h0040_0008, 0);
        vecs[8]  = mk(0, 2'b00, 32'h0,         0, 1, 1, 32'h0040_0008, 0);
        vecs[9]  = mk(1, 2'b01, 32'h0040_0100, 0, 1, 1, 32'h0040_000C, 0); // hs + branch
        vecs[10] = mk(1, 2'b11, 32'h0040_0200, 1, 0, 0, 32'h0040_0100, 0); // jr under stall
        vecs[11] = mk(0, 2'b00, 32'h0,         0, 1, 1, 32'h0040_0200, 0);
        vecs[12] = mk(1, 2'b00, 32'h0,         0, 0, 1, 32'h0040_0204, 0); // seq redirect
        vecs[13] = mk(1, 2'b10, 32'h0040_0200, 0, 1, 1, 32'h0040_0208, 0); // aligned jump
        vecs[14] = mk(1, 2'b11, 32'hFFFF_FFFC, 0, 0, 1, 32'h0040_0200, 0);
        vecs[15] = mk(0, 2'b00, 32'h0,         0, 1, 1, 32'hFFFF_FFFC, 0); // wrap
        vecs[16] = mk(0, 2'b00, 32'h0,         0, 1, 1, 32'h0000_0000, 0);
        vecs[17] = mk(1, 2'b10, 32'h0040_0102, 0, 1, 1, 32'h0000_0004, 0); // misaligned
        vecs[18] = mk(0, 2'b00, 32'h0,         0, 1, 0, 32'h0040_0102, 1); // halted
        vecs[19] = mk(1, 2'b01, 32'h0040_0300, 0, 1, 0, 32'h0040_0102, 1); // redirect ignored
        vecs[20] = mk(0, 2'b00, 32'h0,         0, 1, 0, 32'h0040_0102, 1);

        // ----- reset: two cycles low, release away from the edge
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 32'h0040_0000, 1'b0);
        rst_n = 1'b1;

        exp_hs = 0;
        for (int i = 0; i < NV; i++) begin
            redirect_valid = vecs[i].rdv;
            sel            = vecs[i].sel;
            branch_tgt     = vecs[i].br;
            jump_tgt       = vecs[i].j;
            jr_tgt         = vecs[i].jr;
            stall          = vecs[i].stall;
            imem_req_ready = vecs[i].ready;
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid,
                          vecs[i].exp_addr, vecs[i].exp_mis);
            if (vecs[i].exp_valid && vecs[i].ready) exp_hs++;
            @(posedge clk);
            #1;
        end

`ifdef Y_PC_FETCH_COUNT_EN
        chk("fetch_count", fetch_count, exp_hs);
`endif

        // ----- reset out of HALT, with a redirect pending: reset wins
        idle_inputs();
        redirect_valid = 1'b1; sel = 2'b10; jump_tgt = 32'h0040_0500;
        imem_req_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("halt_reset", 1'b0, 32'h0040_0000, 1'b0);
`ifdef Y_PC_FETCH_COUNT_EN
        chk("fetch_count_reset", fetch_count, 32'd0);
`endif
        idle_inputs();
        rst_n = 1'b1;
        #1;
        check_outputs("reboot_c1", 1'b0, 32'h0040_0000, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("reboot_c2", 1'b1, 32'h0040_0000, 1'b0);

        // ----- a redirect during BOOT has no effect
        redirect_valid = 1'b1; sel = 2'b01; branch_tgt = 32'h0040_0700;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_outputs("boot_redirect", 1'b1, 32'h0040_0000, 1'b0);

        // ----- stalled request never increments even with ready high
        stall = 1'b1; imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("stall_hold", 1'b0, 32'h0040_0000, 1'b0);
        stall = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_stall", 1'b1, 32'h0040_0004, 1'b0);
`ifdef Y_PC_FETCH_COUNT_EN
        chk("fetch_count_after", fetch_count, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end

endmodule
`default_nettype wire
